// File: rtl/qnigma_poly1305_pkg.sv
// Shared Poly1305 types: tag container, tag length and tag-check FSM states.
package qnigma_poly1305_pkg;

    // Tag length in bytes; fixed by the protocol.
    localparam int TAG_BYTES = 16;

    // Element i is wire byte i (byte 0 is transmitted first).
    typedef logic [TAG_BYTES-1:0][7:0] poly_tag_t;

    // Receive-side tag verifier states.
    typedef enum logic [2:0] {
        TC_IDLE      = 3'd0,
        TC_COLLECT   = 3'd1,
        TC_WAIT_CALC = 3'd2,
        TC_COMPARE   = 3'd3,
        TC_REPORT    = 3'd4
    } tag_chk_state_t;

    // Numeric (little-endian) view of a tag: wire byte 0 is the least
    // significant byte, so the packed layout already matches.
    function automatic logic [8*TAG_BYTES-1:0] poly_tag_to_num(input poly_tag_t t);
        return t;
    endfunction

endpackage

// File: rtl/qnigma_poly1305_tag_check.sv
// Receive-side Poly1305 tag verifier: collects the 16 received tag bytes,
// latches the locally computed tag, and compares them over a fixed 16-cycle
// window so the verdict time never depends on the data.
//
// Handshake: a received byte transfers on a clock edge where
// rx_tag_val & rx_tag_rdy; rx_tag_rdy never depends on rx_tag_val.
// calc_val is a one-cycle strobe with no back-pressure; it is taken only in
// IDLE/COLLECT/WAIT_CALC and only if no computed tag is held yet.
module qnigma_poly1305_tag_check
    import qnigma_poly1305_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rx_tag_val,
    input  logic [7:0]     rx_tag_dat,
    output logic           rx_tag_rdy,
    input  logic           calc_val,
    input  poly_tag_t      calc_tag,
    input  logic           abort,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output tag_chk_state_t state_dbg
);

    tag_chk_state_t state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [3:0]     idx_q, idx_d;
    logic [7:0]     diff_q, diff_d;
    logic           calc_have_q, calc_have_d;
    logic           done_q, done_d;
    logic           pass_q, pass_d;

    poly_tag_t      rx_buf_q;
    poly_tag_t      calc_buf_q;

    logic           rx_we;
    logic           calc_we;
    logic           byte_acc;
    logic           calc_acc;
    logic [7:0]     diff_next;

    // Ready and busy are pure decodes of the current state.
    assign rx_tag_rdy = (state_q == TC_IDLE) || (state_q == TC_COLLECT);
    assign busy       = (state_q != TC_IDLE);
    assign done       = done_q;
    assign pass       = pass_q;
    assign state_dbg  = state_q;

    assign byte_acc  = rx_tag_val && rx_tag_rdy;
    assign calc_acc  = calc_val && !calc_have_q &&
                       ((state_q == TC_IDLE) || (state_q == TC_COLLECT) ||
                        (state_q == TC_WAIT_CALC));
    assign diff_next = diff_q | (rx_buf_q[idx_q] ^ calc_buf_q[idx_q]);

    // Next-state, counters, accumulator and verdict; abort overrides all.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        diff_d      = diff_q;
        calc_have_d = calc_have_q;
        done_d      = 1'b0;
        pass_d      = 1'b0;
        rx_we       = 1'b0;
        calc_we     = 1'b0;

        if (abort) begin
            state_d     = TC_IDLE;
            cnt_d       = 4'd0;
            idx_d       = 4'd0;
            diff_d      = 8'd0;
            calc_have_d = 1'b0;
        end else begin
            if (calc_acc) begin
                calc_we     = 1'b1;
                calc_have_d = 1'b1;
            end
            case (state_q)
                TC_IDLE: begin
                    if (byte_acc) begin
                        rx_we   = 1'b1;
                        cnt_d   = 4'd1;
                        state_d = TC_COLLECT;
                    end
                end
                TC_COLLECT: begin
                    if (byte_acc) begin
                        rx_we = 1'b1;
                        cnt_d = cnt_q + 4'd1;
                        // 16th byte: counter wraps to 0 as it leaves COLLECT.
                        if (cnt_q == 4'd15) begin
                            idx_d   = 4'd0;
                            diff_d  = 8'd0;
                            state_d = (calc_have_q || calc_acc) ? TC_COMPARE
                                                                : TC_WAIT_CALC;
                        end
                    end
                end
                TC_WAIT_CALC: begin
                    if (calc_acc) begin
                        state_d = TC_COMPARE;
                    end
                end
                TC_COMPARE: begin
                    // Always all 16 bytes: no early exit on a difference.
                    diff_d = diff_next;
                    idx_d  = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        state_d = TC_REPORT;
                        done_d  = 1'b1;
                        pass_d  = (diff_next == 8'd0);
                    end
                end
                TC_REPORT: begin
                    state_d     = TC_IDLE;
                    cnt_d       = 4'd0;
                    idx_d       = 4'd0;
                    diff_d      = 8'd0;
                    calc_have_d = 1'b0;
                end
                default: begin
                    state_d = TC_IDLE;
                end
            endcase
        end
    end

    // Control state and registered verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= TC_IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= 4'd0;
            diff_q      <= 8'd0;
            calc_have_q <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            diff_q      <= diff_d;
            calc_have_q <= calc_have_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    // Tag buffers; contents only matter inside an active frame.
    always_ff @(posedge clk) begin
        if (rx_we) begin
            rx_buf_q[cnt_q] <= rx_tag_dat;
        end
        if (calc_we) begin
            calc_buf_q <= calc_tag;
        end
    end

endmodule

// File: tb/tb_qnigma_poly1305_tag_check.sv
// Bench for the receive-side Poly1305 tag verifier.
module tb_qnigma_poly1305_tag_check;
    import qnigma_poly1305_pkg::*;

    logic           clk;
    logic           rst_n;
    logic           rx_tag_val;
    logic [7:0]     rx_tag_dat;
    logic           rx_tag_rdy;
    logic           calc_val;
    poly_tag_t      calc_tag;
    logic           abort;
    logic           busy;
    logic           done;
    logic           pass;
    tag_chk_state_t state_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Expected verdicts: {pass, edge count at which done must be seen}.
    logic [32:0] exp_q[$];

    logic [7:0] rfc [16] = '{8'ha8, 8'h06, 8'h1d, 8'hc1, 8'h30, 8'h51, 8'h36, 8'hc6,
                             8'hc2, 8'h2b, 8'h8b, 8'haf, 8'h0c, 8'h01, 8'h27, 8'ha9};
    logic [7:0] bad [16];
    poly_tag_t  good_tag;
    poly_tag_t  zero_tag;

    qnigma_poly1305_tag_check dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_tag_val (rx_tag_val),
        .rx_tag_dat (rx_tag_dat),
        .rx_tag_rdy (rx_tag_rdy),
        .calc_val   (calc_val),
        .calc_tag   (calc_tag),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .state_dbg  (state_dbg)
    );

    // Clock and edge counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops an expectation for every done strobe.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done: done=1 pass=%0b at cycle %0d, expected no verdict", pass, cyc);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    if (pass !== e[32] || cyc !== int'(e[31:0])) begin
                        n_fail++;
                        $display("FAIL verdict: pass=%0b at cycle %0d, expected pass=%0b at cycle %0d",
                                 pass, cyc, e[32], e[31:0]);
                    end
                end
            end else begin
                n_tests++;
                if (pass !== 1'b0) begin
                    n_fail++;
                    $display("FAIL pass_without_done: pass=%0b, expected 0 at cycle %0d", pass, cyc);
                end
            end
        end
    end

    // Drivers: all called at posedge+1.
    task automatic send_byte(input logic [7:0] d, output int e);
        int g;
        g = 0;
        rx_tag_val = 1'b1;
        rx_tag_dat = d;
        while (!rx_tag_rdy && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (g == 100) check("rdy_timeout", 32'(rx_tag_rdy), 32'd1);
        @(posedge clk); #1;
        e = cyc;
        rx_tag_val = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b [16], input int gap, output int last_edge);
        for (int i = 0; i < 16; i++) begin
            send_byte(b[i], last_edge);
            if (i != 15) repeat (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic strobe_calc(input poly_tag_t t, output int e);
        calc_val = 1'b1;
        calc_tag = t;
        @(posedge clk); #1;
        e = cyc;
        calc_val = 1'b0;
    endtask

    task automatic expect_verdict(input logic p, input int at_edge);
        exp_q.push_back({p, 32'(at_edge)});
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 80) begin
            @(posedge clk); #1;
            g++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d verdicts outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int e;
        int le;
        rst_n      = 1'b0;
        rx_tag_val = 1'b0;
        rx_tag_dat = 8'd0;
        calc_val   = 1'b0;
        calc_tag   = '0;
        abort      = 1'b0;
        zero_tag   = '0;
        for (int i = 0; i < 16; i++) good_tag[i] = rfc[i];

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_rdy",  32'(rx_tag_rdy), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_state", 32'(state_dbg), 32'(TC_IDLE));

        // RFC 8439 tag, calc first, back-to-back bytes.
        strobe_calc(good_tag, e);
        send_frame(rfc, 0, le);
        check("collect_done_busy", 32'(busy), 32'd1);
        expect_verdict(1'b1, le + 16);
        wait_drain();

        // Last byte wrong.
        for (int i = 0; i < 16; i++) bad[i] = rfc[i];
        bad[15] = 8'ha8;
        strobe_calc(good_tag, e);
        send_frame(bad, 0, le);
        expect_verdict(1'b0, le + 16);
        wait_drain();

        // First byte wrong: same verdict latency.
        for (int i = 0; i < 16; i++) bad[i] = rfc[i];
        bad[0] = 8'ha9;
        strobe_calc(good_tag, e);
        send_frame(bad, 0, le);
        expect_verdict(1'b0, le + 16);
        wait_drain();

        // Late calc: bytes first, stall in WAIT_CALC for 40 cycles.
        send_frame(rfc, 0, le);
        for (int i = 0; i < 40; i++) begin
            check("wait_rdy", 32'(rx_tag_rdy), 32'd0);
            check("wait_busy", 32'(busy), 32'd1);
            @(posedge clk); #1;
        end
        strobe_calc(good_tag, e);
        expect_verdict(1'b1, e + 16);
        wait_drain();

        // Abort at byte 7 together with a valid byte.
        strobe_calc(good_tag, e);
        for (int i = 0; i < 7; i++) send_byte(rfc[i], le);
        rx_tag_val = 1'b1;
        rx_tag_dat = rfc[7];
        abort      = 1'b1;
        @(posedge clk); #1;
        abort      = 1'b0;
        rx_tag_val = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rdy", 32'(rx_tag_rdy), 32'd1);
        check("abort_state", 32'(state_dbg), 32'(TC_IDLE));
        repeat (25) begin
            @(posedge clk); #1;
        end
        strobe_calc(good_tag, e);
        send_frame(rfc, 0, le);
        expect_verdict(1'b1, le + 16);
        wait_drain();

        // Double calc_val: second (all-zero) tag must be ignored.
        strobe_calc(good_tag, e);
        strobe_calc(zero_tag, e);
        send_frame(rfc, 0, le);
        expect_verdict(1'b1, le + 16);
        wait_drain();

        // Same, with a byte only every third cycle.
        strobe_calc(good_tag, e);
        strobe_calc(zero_tag, e);
        send_frame(rfc, 2, le);
        expect_verdict(1'b1, le + 16);
        wait_drain();

        // Calc strobe in the same cycle as the 16th byte.
        for (int i = 0; i < 15; i++) send_byte(rfc[i], le);
        calc_val = 1'b1;
        calc_tag = good_tag;
        send_byte(rfc[15], le);
        calc_val = 1'b0;
        expect_verdict(1'b1, le + 16);
        wait_drain();

        // Reset in the middle of COMPARE (idx 5): no verdict afterwards.
        strobe_calc(good_tag, e);
        send_frame(rfc, 0, le);
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_state", 32'(state_dbg), 32'(TC_COMPARE));
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_rdy", 32'(rx_tag_rdy), 32'd1);
        #2;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("post_rst_busy", 32'(busy), 32'd0);

        // Recovery frame after the reset.
        strobe_calc(good_tag, e);
        send_frame(rfc, 0, le);
        expect_verdict(1'b1, le + 16);
        wait_drain();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
